pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports clk_i in 1 (sole clock) and rst_ni in 1 (asynchronous, active-low reset).
REQ-002 SHALL have inputs load_use_hazard_i 1, div_busy_i 1 (multi-cycle EX op in progress) and ex_jump_flag_i 1 (EX branch/jump taken).
REQ-003 SHALL have inputs exc_req_i 1, exc_cause_i 4 and exc_pc_i 32 (synchronous exception from EX and its PC).
REQ-004 SHALL have inputs irq_i 1, irq_cause_i 4, mie_i 1 (global enable) and ex_pc_i 32 (PC of the instruction in EX).
REQ-005 SHALL have inputs mret_i 1, mtvec_i 32 and mepc_i 32.
REQ-006 SHALL have outputs stall_o 1 and flush_o 1, which drive the fetch stage's stall and refresh inputs.
REQ-007 SHALL have outputs ctrl_jump_flag_o 1 and ctrl_jump_addr_o 32, which drive the fetch stage's control-redirect inputs.
REQ-008 SHALL have outputs csr_we_o 1, csr_mepc_o 32, csr_mcause_o 32 and csr_mret_o 1 (trap entry/exit strobes to the CSR file).

Function
REQ-009 SHALL implement FSM states RUN, TRAP_CSR, TRAP_JUMP and MRET_JUMP; each non-RUN state SHALL last exactly 1 cycle.
REQ-010 In RUN, event priority SHALL be: exc_req_i > mret_i > (irq_i & mie_i & !div_busy_i) > ex_jump_flag_i > stall.
REQ-011 In RUN on exc_req_i, the block SHALL latch epc=exc_pc_i and mcause={1'b0,27'b0,exc_cause_i}, and go to TRAP_CSR.
REQ-012 In RUN on a taken interrupt, the block SHALL latch epc=ex_pc_i and mcause={1'b1,27'b0,irq_cause_i}, and go to TRAP_CSR.
REQ-013 In RUN on mret_i with no exception, the block SHALL go to MRET_JUMP.
REQ-014 In a trap/mret detection cycle: flush_o=1 and stall_o=0.
REQ-015 In RUN with no trap event: flush_o=ex_jump_flag_i; stall_o=(load_use_hazard_i|div_busy_i)&!ex_jump_flag_i.
REQ-016 In TRAP_CSR: csr_we_o=1, csr_mepc_o=latched epc, csr_mcause_o=latched mcause, stall_o=1 and flush_o=1; next state TRAP_JUMP.
REQ-017 In TRAP_JUMP: ctrl_jump_flag_o=1, flush_o=1 and stall_o=0; next state RUN.
REQ-018 ctrl_jump_addr_o in TRAP_JUMP SHALL be {mtvec_i[31:2],2'b00}, plus 4*mcause[3:0] when mtvec_i[1:0]==2'b01 and mcause[31]==1 (32-bit, wraps modulo 2^32).
REQ-019 In MRET_JUMP: ctrl_jump_flag_o=1, ctrl_jump_addr_o=mepc_i, csr_mret_o=1 and flush_o=1; next state RUN.
REQ-020 Outside RUN, all of exc_req_i, irq_i, mret_i, ex_jump_flag_i, load_use_hazard_i and div_busy_i SHALL be ignored.
REQ-021 An interrupt arriving while div_busy_i=1 SHALL be held off and taken in the first RUN cycle with div_busy_i=0 if irq_i&mie_i is still asserted; no internal pending latch.
REQ-022 ctrl_jump_flag_o, ctrl_jump_addr_o, csr_we_o, csr_mepc_o, csr_mcause_o and csr_mret_o SHALL depend only on state and latched registers (plus mtvec_i/mepc_i), and SHALL be 0 in RUN.

Reset
REQ-023 While rst_ni=0: state=RUN, latched epc/mcause=0, and every output=0, including stall_o and flush_o (masked regardless of inputs).
REQ-024 Reset asserted mid-trap SHALL abort the sequence immediately; no CSR write or jump SHALL occur after release.

Structure
REQ-025 A shared package pipe_ctrl_pkg SHALL hold the state enum, the MCAUSE_IRQ_BIT index (31) and the MTVEC_MODE_VECTORED constant (2'b01).
REQ-026 Target-address computation SHALL be one combinational sub-module, trap_vec_calc (inputs mtvec and mcause, output addr); the remainder is flat.

Verification
REQ-027 Bench SHALL cover: exc_req_i=1, exc_cause_i=2, exc_pc_i=0x100, mtvec_i=0x800 -> flush, then csr_we_o with mepc=0x100, mcause=0x2, then ctrl_jump to 0x800 one cycle later.
REQ-028 Bench SHALL cover: irq_i=mie_i=1, irq_cause_i=7, mtvec_i=0x801, ex_pc_i=0x24 -> mcause=0x80000007, mepc=0x24, jump to 0x81C.
REQ-029 Bench SHALL cover: irq_i=1 while div_busy_i=1 for 3 cycles -> stall_o=1 and no trap for those 3 cycles; trap taken in cycle 4.
REQ-030 Bench SHALL cover: exc_req_i, mret_i and ex_jump_flag_i asserted in the same cycle -> only the exception sequence runs; csr_mret_o stays 0.
REQ-031 Bench SHALL cover: mret_i=1, mepc_i=0x200 -> next cycle ctrl_jump_flag_o=1, addr=0x200, csr_mret_o=1; RUN resumes after.
REQ-032 Bench SHALL cover: rst_ni dropped while in TRAP_CSR -> all outputs 0 at once; after release, no csr_we_o and no jump occur.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
//   state_e             : controller FSM states
//   MCAUSE_IRQ_BIT      : mcause bit marking an interrupt (vs. exception)
//   MTVEC_MODE_VECTORED : mtvec[1:0] encoding for vectored interrupt mode
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun,
    StTrapCsr,
    StTrapJump,
    StMretJump
  } state_e;

  localparam int unsigned MCAUSE_IRQ_BIT      = 31;
  localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/pipe_ctrl_trap_vec_calc.sv
// Trap target address calculation (purely combinational).
//   mtvec_i  : trap vector base register, low two bits select the mode
//   mcause_i : cause of the trap being taken
//   addr_o   : base aligned to 4 bytes, offset by 4*cause for vectored interrupts
module trap_vec_calc
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mcause_i,
  output logic [31:0] addr_o
);

  logic [31:0] offset;
  logic        unused_mcause;

  // Only the interrupt flag and the low cause bits affect the target.
  assign unused_mcause = ^mcause_i[30:4];

  always_comb begin
    offset = '0;
    if (mtvec_i[1:0] == MTVEC_MODE_VECTORED && mcause_i[MCAUSE_IRQ_BIT]) begin
      offset = {26'b0, mcause_i[3:0], 2'b00};
    end
    // Wraps modulo 2^32 by construction.
    addr_o = {mtvec_i[31:2], 2'b00} + offset;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / trap controller.
// Inputs : hazard and multi-cycle busy flags, EX jump flag, synchronous exception
//          (cause, PC), interrupt request (cause, global enable, EX PC), mret request,
//          mtvec and mepc from the CSR file.
// Outputs: stall_o / flush_o to fetch, ctrl_jump_flag_o / ctrl_jump_addr_o redirect,
//          csr_we_o / csr_mepc_o / csr_mcause_o trap-entry write, csr_mret_o trap exit.
// A trap takes three cycles: detection (flush), CSR write, jump to the vector.
// mret takes two: detection (flush), jump to mepc.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        load_use_hazard_i,
  input  logic        div_busy_i,
  input  logic        ex_jump_flag_i,

  input  logic        exc_req_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_pc_i,

  input  logic        irq_i,
  input  logic [3:0]  irq_cause_i,
  input  logic        mie_i,
  input  logic [31:0] ex_pc_i,

  input  logic        mret_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,

  output logic        stall_o,
  output logic        flush_o,
  output logic        ctrl_jump_flag_o,
  output logic [31:0] ctrl_jump_addr_o,
  output logic        csr_we_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic        csr_mret_o
);

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] vec_addr;
  logic        stall_raw, flush_raw;
  logic        irq_take;

  trap_vec_calc u_trap_vec_calc (
    .mtvec_i  (mtvec_i),
    .mcause_i (mcause_q),
    .addr_o   (vec_addr)
  );

  // Interrupts are held off while a multi-cycle op is busy; no pending latch,
  // so the request must still be present once the op completes.
  assign irq_take = irq_i & mie_i & ~div_busy_i;

  always_comb begin
    state_d          = state_q;
    epc_d            = epc_q;
    mcause_d         = mcause_q;
    stall_raw        = 1'b0;
    flush_raw        = 1'b0;
    ctrl_jump_flag_o = 1'b0;
    ctrl_jump_addr_o = '0;
    csr_we_o         = 1'b0;
    csr_mepc_o       = '0;
    csr_mcause_o     = '0;
    csr_mret_o       = 1'b0;

    unique case (state_q)
      StRun: begin
        if (exc_req_i) begin
          epc_d     = exc_pc_i;
          mcause_d  = {1'b0, 27'b0, exc_cause_i};
          flush_raw = 1'b1;
          state_d   = StTrapCsr;
        end else if (mret_i) begin
          flush_raw = 1'b1;
          state_d   = StMretJump;
        end else if (irq_take) begin
          epc_d     = ex_pc_i;
          mcause_d  = {1'b1, 27'b0, irq_cause_i};
          flush_raw = 1'b1;
          state_d   = StTrapCsr;
        end else begin
          flush_raw = ex_jump_flag_i;
          stall_raw = (load_use_hazard_i | div_busy_i) & ~ex_jump_flag_i;
        end
      end
      StTrapCsr: begin
        csr_we_o     = 1'b1;
        csr_mepc_o   = epc_q;
        csr_mcause_o = mcause_q;
        stall_raw    = 1'b1;
        flush_raw    = 1'b1;
        state_d      = StTrapJump;
      end
      StTrapJump: begin
        ctrl_jump_flag_o = 1'b1;
        ctrl_jump_addr_o = vec_addr;
        flush_raw        = 1'b1;
        state_d          = StRun;
      end
      StMretJump: begin
        ctrl_jump_flag_o = 1'b1;
        ctrl_jump_addr_o = mepc_i;
        csr_mret_o       = 1'b1;
        flush_raw        = 1'b1;
        state_d          = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // stall/flush are input-dependent in RUN, so mask them while reset is held.
  assign stall_o = stall_raw & rst_ni;
  assign flush_o = flush_raw & rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StRun;
      epc_q    <= '0;
      mcause_q <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      mcause_q <= mcause_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic,
// compared against a queue-based model of the upcoming controller cycles.
module tb_pipe_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        load_use_hazard_i, div_busy_i, ex_jump_flag_i;
  logic        exc_req_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_pc_i;
  logic        irq_i;
  logic [3:0]  irq_cause_i;
  logic        mie_i;
  logic [31:0] ex_pc_i;
  logic        mret_i;
  logic [31:0] mtvec_i, mepc_i;
  logic        stall_o, flush_o, ctrl_jump_flag_o, csr_we_o, csr_mret_o;
  logic [31:0] ctrl_jump_addr_o, csr_mepc_o, csr_mcause_o;

  pipe_ctrl dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .load_use_hazard_i (load_use_hazard_i),
    .div_busy_i        (div_busy_i),
    .ex_jump_flag_i    (ex_jump_flag_i),
    .exc_req_i         (exc_req_i),
    .exc_cause_i       (exc_cause_i),
    .exc_pc_i          (exc_pc_i),
    .irq_i             (irq_i),
    .irq_cause_i       (irq_cause_i),
    .mie_i             (mie_i),
    .ex_pc_i           (ex_pc_i),
    .mret_i            (mret_i),
    .mtvec_i           (mtvec_i),
    .mepc_i            (mepc_i),
    .stall_o           (stall_o),
    .flush_o           (flush_o),
    .ctrl_jump_flag_o  (ctrl_jump_flag_o),
    .ctrl_jump_addr_o  (ctrl_jump_addr_o),
    .csr_we_o          (csr_we_o),
    .csr_mepc_o        (csr_mepc_o),
    .csr_mcause_o      (csr_mcause_o),
    .csr_mret_o        (csr_mret_o)
  );

  always #5 clk_i = ~clk_i;

  // Kinds of scheduled non-RUN cycles.
  localparam int KCsr   = 1;
  localparam int KTJump = 2;
  localparam int KMJump = 3;

  typedef struct {
    int          kind;
    logic [31:0] epc;
    logic [31:0] cause;
  } sched_t;

  sched_t      sched[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] obs_stall, obs_flush, obs_jf, obs_jaddr, obs_we, obs_mepc, obs_mcause, obs_mret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_vec(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] a;
    a = tvec & 32'hFFFF_FFFC;
    if (tvec[1:0] == 2'b01 && cause[31]) a = a + 32'(cause[3:0]) * 32'd4;
    return a;
  endfunction

  task automatic push_sched(input int kind, input logic [31:0] epc, input logic [31:0] cause);
    sched_t s;
    s.kind  = kind;
    s.epc   = epc;
    s.cause = cause;
    sched.push_back(s);
  endtask

  // Check the current cycle at the falling edge, advance the model, then
  // return just after the next rising edge where inputs may be changed.
  task automatic run_cycle();
    logic [31:0] e_stall, e_flush, e_jf, e_jaddr, e_we, e_mepc, e_mcause, e_mret;
    sched_t      s;
    @(negedge clk_i);
    {e_stall, e_flush, e_jf, e_jaddr, e_we, e_mepc, e_mcause, e_mret} = '0;
    if (!rst_ni) begin
      sched.delete();
    end else if (sched.size() == 0) begin
      if (exc_req_i) begin
        e_flush = 1;
        push_sched(KCsr, exc_pc_i, {28'b0, exc_cause_i});
        push_sched(KTJump, exc_pc_i, {28'b0, exc_cause_i});
      end else if (mret_i) begin
        e_flush = 1;
        push_sched(KMJump, '0, '0);
      end else if (irq_i && mie_i && !div_busy_i) begin
        e_flush = 1;
        push_sched(KCsr, ex_pc_i, {1'b1, 27'b0, irq_cause_i});
        push_sched(KTJump, ex_pc_i, {1'b1, 27'b0, irq_cause_i});
      end else begin
        e_flush = 32'(ex_jump_flag_i);
        e_stall = 32'((load_use_hazard_i || div_busy_i) && !ex_jump_flag_i);
      end
    end else begin
      s = sched.pop_front();
      e_flush = 1;
      if (s.kind == KCsr) begin
        e_we     = 1;
        e_mepc   = s.epc;
        e_mcause = s.cause;
        e_stall  = 1;
      end else if (s.kind == KTJump) begin
        e_jf    = 1;
        e_jaddr = ref_vec(mtvec_i, s.cause);
      end else begin
        e_jf    = 1;
        e_jaddr = mepc_i;
        e_mret  = 1;
      end
    end
    obs_stall  = 32'(stall_o);
    obs_flush  = 32'(flush_o);
    obs_jf     = 32'(ctrl_jump_flag_o);
    obs_jaddr  = ctrl_jump_addr_o;
    obs_we     = 32'(csr_we_o);
    obs_mepc   = csr_mepc_o;
    obs_mcause = csr_mcause_o;
    obs_mret   = 32'(csr_mret_o);
    check("stall", obs_stall, e_stall);
    check("flush", obs_flush, e_flush);
    check("jump_flag", obs_jf, e_jf);
    check("jump_addr", obs_jaddr, e_jaddr);
    check("csr_we", obs_we, e_we);
    check("csr_mepc", obs_mepc, e_mepc);
    check("csr_mcause", obs_mcause, e_mcause);
    check("csr_mret", obs_mret, e_mret);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    load_use_hazard_i = 0; div_busy_i = 0; ex_jump_flag_i = 0;
    exc_req_i = 0; irq_i = 0; mie_i = 0; mret_i = 0;
  endtask

  task automatic randomize_inputs();
    load_use_hazard_i = ($urandom_range(3) == 0);
    div_busy_i        = ($urandom_range(3) == 0);
    ex_jump_flag_i    = ($urandom_range(4) == 0);
    exc_req_i         = ($urandom_range(15) == 0);
    exc_cause_i       = 4'($urandom);
    exc_pc_i          = $urandom;
    irq_i             = ($urandom_range(5) == 0);
    irq_cause_i       = 4'($urandom);
    mie_i             = ($urandom_range(3) != 0);
    ex_pc_i           = $urandom;
    mret_i            = ($urandom_range(15) == 0);
    mtvec_i           = $urandom;
    if ($urandom_range(1) == 0) mtvec_i[1:0] = 2'b01;
    mepc_i            = $urandom;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    exc_cause_i = '0; exc_pc_i = '0; irq_cause_i = '0; ex_pc_i = '0;
    mtvec_i = '0; mepc_i = '0;

    // Outputs masked during reset even with active requests.
    load_use_hazard_i = 1; ex_jump_flag_i = 1; exc_req_i = 1;
    run_cycle();
    run_cycle();
    idle();
    rst_ni = 1'b1;
    run_cycle();

    // Synchronous exception into direct-mode vector.
    exc_req_i = 1; exc_cause_i = 4'd2; exc_pc_i = 32'h100; mtvec_i = 32'h800;
    run_cycle();
    check("exc_flush", obs_flush, 32'd1);
    idle();
    run_cycle();
    check("exc_we", obs_we, 32'd1);
    check("exc_mepc", obs_mepc, 32'h100);
    check("exc_mcause", obs_mcause, 32'h2);
    run_cycle();
    check("exc_jaddr", obs_jaddr, 32'h800);
    run_cycle();

    // Vectored interrupt.
    irq_i = 1; mie_i = 1; irq_cause_i = 4'd7; mtvec_i = 32'h801; ex_pc_i = 32'h24;
    run_cycle();
    idle();
    run_cycle();
    check("irq_mcause", obs_mcause, 32'h8000_0007);
    check("irq_mepc", obs_mepc, 32'h24);
    run_cycle();
    check("irq_jaddr", obs_jaddr, 32'h81C);
    run_cycle();

    // Interrupt held off by a busy divider for three cycles.
    irq_i = 1; mie_i = 1; div_busy_i = 1; irq_cause_i = 4'd3; ex_pc_i = 32'h48;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("div_hold_stall", obs_stall, 32'd1);
      check("div_hold_flush", obs_flush, 32'd0);
    end
    div_busy_i = 0;
    run_cycle();
    check("div_release_flush", obs_flush, 32'd1);
    idle();
    run_cycle();
    check("div_release_we", obs_we, 32'd1);
    run_cycle();
    run_cycle();

    // Exception wins over simultaneous mret and jump; mret held but ignored.
    exc_req_i = 1; mret_i = 1; ex_jump_flag_i = 1; exc_cause_i = 4'd5; exc_pc_i = 32'h40;
    mepc_i = 32'h300; mtvec_i = 32'h900;
    run_cycle();
    exc_req_i = 0; ex_jump_flag_i = 0;
    run_cycle();
    check("prio_we", obs_we, 32'd1);
    check("prio_mret", obs_mret, 32'd0);
    run_cycle();
    check("prio_jaddr", obs_jaddr, 32'h900);
    check("prio_mret2", obs_mret, 32'd0);
    idle();
    run_cycle();

    // mret.
    mret_i = 1; mepc_i = 32'h200;
    run_cycle();
    idle();
    run_cycle();
    check("mret_jf", obs_jf, 32'd1);
    check("mret_addr", obs_jaddr, 32'h200);
    check("mret_strobe", obs_mret, 32'd1);
    run_cycle();
    check("mret_resume_jf", obs_jf, 32'd0);

    // Reset while in TRAP_CSR aborts the trap.
    exc_req_i = 1; exc_cause_i = 4'd1; exc_pc_i = 32'h500;
    run_cycle();
    idle();
    rst_ni = 1'b0;
    #1;
    check("rst_now_we", 32'(csr_we_o), 32'd0);
    check("rst_now_flush", 32'(flush_o), 32'd0);
    check("rst_now_stall", 32'(stall_o), 32'd0);
    run_cycle();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("post_rst_we", obs_we, 32'd0);
      check("post_rst_jf", obs_jf, 32'd0);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      if (!rst_ni) rst_ni = 1'b1;
      else if ($urandom_range(299) == 0) rst_ni = 1'b0;
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
